// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment bit positions, the hex pattern table
// and the capture FSM state encoding, used by both the encoder and readback sides.
package seg_pkg;

  localparam int SEG_A = 7;
  localparam int SEG_B = 6;
  localparam int SEG_C = 5;
  localparam int SEG_D = 4;
  localparam int SEG_E = 3;
  localparam int SEG_F = 2;
  localparam int SEG_G = 1;
  localparam int SEG_H = 0;

  // a..g patterns for nibbles 0..F; element 0 is the leftmost entry.
  localparam logic [0:15][6:0] SEG_TABLE = {
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg_scan_capture_if.sv
// Display-side and readback signals of seg_scan_capture.
// SEG_BLANK_DETECT_EN adds the per-digit blank flags.
interface seg_scan_capture_if #(
  parameter int DIGITS = 4
);
  logic [DIGITS-1:0]   an;
  logic [7:0]          abcdefgh;
  logic [4*DIGITS-1:0] hex_value;
  logic [DIGITS-1:0]   dp;
  logic                frame_valid;
  logic                seg_err;
`ifdef SEG_BLANK_DETECT_EN
  logic [DIGITS-1:0]   blank;

  modport master (output an, abcdefgh,
                  input  hex_value, dp, frame_valid, seg_err, blank);
  modport slave  (input  an, abcdefgh,
                  output hex_value, dp, frame_valid, seg_err, blank);
`else
  modport master (output an, abcdefgh,
                  input  hex_value, dp, frame_valid, seg_err);
  modport slave  (input  an, abcdefgh,
                  output hex_value, dp, frame_valid, seg_err);
`endif
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational a..g pattern to hex nibble decoder.
// With SEG_BLANK_DETECT_EN an all-dark pattern decodes as a valid blank digit.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
`ifdef SEG_BLANK_DETECT_EN
  output logic       blank,
`endif
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (seg == SEG_TABLE[k]) begin
        nibble = 4'(k);
        valid  = 1'b1;
      end
    end
`ifdef SEG_BLANK_DETECT_EN
    blank = (seg == 7'h00);
    if (blank) valid = 1'b1;
`endif
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Readback of a multiplexed seven-segment display: tracks each lit digit until it
// is stable, decodes it and emits a frame once every digit has been seen.
// Optional macro SEG_BLANK_DETECT_EN: accept all-dark digits and report them on blank.
//
// state  | meaning
// IDLE   | no valid digit select in the sample
// TRACK  | counting consecutive identical samples of one key
// LOCKED | key captured; holding until it changes
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  seg_scan_capture_if.slave bus
);

  localparam logic [7:0]        STABLE_LIM = 8'(STABLE_CYCLES);
  localparam logic [DIGITS-1:0] ALL_SEEN   = '1;
  localparam int                KW         = DIGITS + 8;

  logic [DIGITS-1:0]   an_q;
  logic [7:0]          seg_q;
  logic [7:0]          seg_lvl;
  logic [6:0]          dec_in;
  logic [3:0]          dec_nib;
  logic                dec_valid;
  logic [KW-1:0]       key_now;
  logic [KW-1:0]       key_trk;
  logic                sel_ok;
  logic                do_cap;
  logic [DIGITS-1:0]   seen;
  logic [DIGITS-1:0]   seen_base;
  logic [7:0]          cnt;
  seg_state_e          state;
  logic [4*DIGITS-1:0] hex_r;
  logic [DIGITS-1:0]   dp_r;
  logic                frame_r;
  logic                err_r;
`ifdef SEG_BLANK_DETECT_EN
  logic                dec_blank;
  logic [DIGITS-1:0]   blank_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= 8'h00;
    end else begin
      an_q  <= bus.an;
      seg_q <= bus.abcdefgh;
    end
  end

  assign seg_lvl = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dec_in  = {seg_lvl[SEG_A], seg_lvl[SEG_B], seg_lvl[SEG_C], seg_lvl[SEG_D],
                    seg_lvl[SEG_E], seg_lvl[SEG_F], seg_lvl[SEG_G]};
  assign key_now = {an_q, seg_q};
  assign sel_ok  = $onehot(~an_q);

  seg_pattern_decode u_decode (
    .seg    (dec_in),
    .nibble (dec_nib),
`ifdef SEG_BLANK_DETECT_EN
    .blank  (dec_blank),
`endif
    .valid  (dec_valid)
  );

  // The sample that completes the stability run captures in the same edge that enters LOCKED.
  assign do_cap    = (state == TRACK) && sel_ok && (key_now == key_trk)
                     && ((cnt + 8'd1) == STABLE_LIM);
  // A full mask is cleared the cycle after it fills; a capture then starts the new mask.
  assign seen_base = (seen == ALL_SEEN) ? '0 : seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      key_trk <= '0;
      seen    <= '0;
      hex_r   <= '0;
      dp_r    <= '0;
      frame_r <= 1'b0;
      err_r   <= 1'b0;
`ifdef SEG_BLANK_DETECT_EN
      blank_r <= '0;
`endif
    end else begin
      frame_r <= (seen == ALL_SEEN);
      err_r   <= do_cap && !dec_valid;
      seen    <= seen_base | ((do_cap && dec_valid) ? ~an_q : '0);

      if (do_cap && dec_valid) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (!an_q[i]) begin
            hex_r[4*i +: 4] <= dec_nib;
            dp_r[i]         <= seg_lvl[SEG_H];
`ifdef SEG_BLANK_DETECT_EN
            blank_r[i]      <= dec_blank;
`endif
          end
        end
      end

      case (state)
        IDLE: begin
          if (sel_ok) begin
            state   <= TRACK;
            cnt     <= 8'd1;
            key_trk <= key_now;
          end else begin
            cnt <= 8'd0;
          end
        end
        TRACK: begin
          if (!sel_ok) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (key_now == key_trk) begin
            if (do_cap) begin
              state <= LOCKED;
              cnt   <= STABLE_LIM;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else begin
            cnt     <= 8'd1;
            key_trk <= key_now;
          end
        end
        LOCKED: begin
          if (!sel_ok) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (key_now != key_trk) begin
            state   <= TRACK;
            cnt     <= 8'd1;
            key_trk <= key_now;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign bus.hex_value   = hex_r;
  assign bus.dp          = dp_r;
  assign bus.frame_valid = frame_r;
  assign bus.seg_err     = err_r;
`ifdef SEG_BLANK_DETECT_EN
  assign bus.blank       = blank_r;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture (DIGITS=4, STABLE_CYCLES=3).
// Build with SEG_BLANK_DETECT_EN to exercise blank-digit capture.
module tb_seg_scan_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
  } frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_capture_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_capture #(
    .DIGITS         (DIGITS),
    .STABLE_CYCLES  (STABLE),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  frame_t      exp_q[$];
  frame_t      f_got;
  int          pushed      = 0;
  int          frames_seen = 0;
  int          err_seen    = 0;
  int          exp_err     = 0;
  logic [15:0] exp_hex     = '0;
  logic [3:0]  exp_dp      = '0;
  logic [3:0]  exp_seen    = '0;
  logic [3:0]  exp_blank   = '0;
  logic [11:0] last_key    = 12'hF00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.seg_err === 1'b1) err_seen++;
      if (bus.frame_valid === 1'b1) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          chk("frame_unexp", frames_seen, pushed);
        end else begin
          f_got = exp_q.pop_front();
          chk("frame_hex", 32'(bus.hex_value), 32'(f_got.hex));
          chk("frame_dp", 32'(bus.dp), 32'(f_got.dp));
        end
      end
    end
  end

  // Drive one digit dwell; the model decides from the stimulus alone whether it captures.
  task automatic show(input logic [3:0] a, input logic [6:0] pat, input logic h,
                      input int cycles, input logic ok, input logic [3:0] nib);
    int          d;
    int          zeros;
    logic        capt;
    logic [3:0]  old_slot;
    logic [11:0] key;
    frame_t      fr;
    zeros = 0;
    d     = 0;
    for (int i = 0; i < 4; i++) begin
      if (!a[i]) begin
        zeros++;
        d = i;
      end
    end
    key      = {a, pat, h};
    capt     = (zeros == 1) && (cycles >= STABLE) && (key != last_key);
    last_key = key;
    old_slot = exp_hex[4*d +: 4];
    if (capt) begin
      if (ok) begin
        exp_hex[4*d +: 4] = nib;
        exp_dp[d]         = h;
        exp_blank[d]      = (pat == 7'h00);
        exp_seen[d]       = 1'b1;
        if (exp_seen == 4'hF) begin
          fr.hex = exp_hex;
          fr.dp  = exp_dp;
          exp_q.push_back(fr);
          pushed++;
          exp_seen = '0;
        end
      end else begin
        exp_err++;
      end
    end
    bus.an       = a;
    bus.abcdefgh = {pat, h};
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (capt && ok && k == STABLE)     chk("lat_early", 32'(bus.hex_value[4*d +: 4]), 32'(old_slot));
      if (capt && ok && k == STABLE + 1) chk("lat_cap", 32'(bus.hex_value[4*d +: 4]), 32'(nib));
    end
  endtask

  task automatic step_check(input string tag);
    #1;
    chk({tag, "_hex"}, 32'(bus.hex_value), 32'(exp_hex));
    chk({tag, "_dp"}, 32'(bus.dp), 32'(exp_dp));
    chk({tag, "_err"}, err_seen, exp_err);
`ifdef SEG_BLANK_DETECT_EN
    chk({tag, "_blank"}, 32'(bus.blank), 32'(exp_blank));
`endif
  endtask

  initial begin
    bus.an       = '1;
    bus.abcdefgh = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_hex", 32'(bus.hex_value), 32'h0);
    chk("rst_fv", 32'(bus.frame_valid), 32'h0);
    chk("rst_err", 32'(bus.seg_err), 32'h0);
    rst_n = 1'b1;

    // Plain scan of four digits, one frame.
    show(4'b1110, 7'h30, 1'b0, 5, 1'b1, 4'h1);
    show(4'b1101, 7'h6D, 1'b0, 5, 1'b1, 4'h2);
    show(4'b1011, 7'h79, 1'b0, 5, 1'b1, 4'h3);
    show(4'b0111, 7'h33, 1'b0, 5, 1'b1, 4'h4);
    step_check("scan");
    chk("scan_4321", 32'(bus.hex_value), 32'h4321);

    // Too-short dwell on digit 0, then a real capture on digit 1.
    show(4'b1110, 7'h7E, 1'b0, 2, 1'b1, 4'h0);
    show(4'b1101, 7'h5B, 1'b0, 4, 1'b1, 4'h5);
    step_check("short");

    // All-dark digit with decimal point.
`ifdef SEG_BLANK_DETECT_EN
    show(4'b1011, 7'h00, 1'b1, 4, 1'b1, 4'h0);
`else
    show(4'b1011, 7'h00, 1'b1, 4, 1'b0, 4'h0);
`endif
    step_check("dark");

    // Two anodes low: no select.
    show(4'b1100, 7'h30, 1'b0, 10, 1'b1, 4'h1);
    step_check("multi");

    // Reset mid-track after three digits.
    show(4'b1110, 7'h4E, 1'b0, 5, 1'b1, 4'hC);
    show(4'b1101, 7'h3D, 1'b0, 5, 1'b1, 4'hD);
    show(4'b1011, 7'h77, 1'b0, 5, 1'b1, 4'hA);
    show(4'b0111, 7'h33, 1'b0, 2, 1'b1, 4'h4);
    rst_n = 1'b0;
    #1;
    chk("arst_hex", 32'(bus.hex_value), 32'h0);
    chk("arst_dp", 32'(bus.dp), 32'h0);
    chk("arst_fv", 32'(bus.frame_valid), 32'h0);
    chk("arst_err", 32'(bus.seg_err), 32'h0);
`ifdef SEG_BLANK_DETECT_EN
    chk("arst_blank", 32'(bus.blank), 32'h0);
`endif
    exp_hex   = '0;
    exp_dp    = '0;
    exp_seen  = '0;
    exp_blank = '0;
    last_key  = 12'hF00;
    @(negedge clk);
    rst_n = 1'b1;

    show(4'b1110, 7'h30, 1'b0, 5, 1'b1, 4'h1);
    show(4'b1101, 7'h6D, 1'b1, 5, 1'b1, 4'h2);
    show(4'b1011, 7'h4F, 1'b0, 5, 1'b1, 4'hE);
    show(4'b0111, 7'h1F, 1'b1, 5, 1'b1, 4'hB);
    step_check("rescan");

    // Three passes of F with long dwells.
    for (int p = 0; p < 3; p++) begin
      show(4'b1110, 7'h47, 1'b0, 6, 1'b1, 4'hF);
      show(4'b1101, 7'h47, 1'b0, 6, 1'b1, 4'hF);
      show(4'b1011, 7'h47, 1'b0, 6, 1'b1, 4'hF);
      show(4'b0111, 7'h47, 1'b0, 6, 1'b1, 4'hF);
    end
    bus.an = '1;
    repeat (6) @(negedge clk);
    step_check("fff");
    chk("fff_hex", 32'(bus.hex_value), 32'hFFFF);
    chk("frames", frames_seen, pushed);
    chk("queue_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
